mmi_cp_sequencer: RTL and testbench

Command sequencer between the CPU register bus and the coprocessor's 64-bit MMI command / 24-bit MMI status port. Software assembles 64-bit command words through two 32-bit registers; the block queues them in a small FIFO. It issues them one at a time with a start pulse, waits for the coprocessor's done pulse or a timeout, and captures the 24-bit status word into a readable result register. Only one command is in flight at any time.

---
 rtl/mmi_cp_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mmi_cp_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmi_cp_sequencer.sv
// Command sequencer between the CPU register bus and the coprocessor MMI port.
// Queues 64-bit commands, issues them one at a time and captures the 24-bit status.
module mmi_cp_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq,
    output logic [63:0] o_mmi,
    output logic        o_start,
    input  logic [23:0] i_mmi
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;

    logic [63:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [4:0]       fifo_count;
    logic [31:0]      staging;
    logic [15:0]      wait_cnt;
    logic [15:0]      wait_next;
    logic [23:0]      result;
    logic             result_valid;
    logic             timeout_flag;
    logic             overflow_flag;

    logic push_req;
    logic push;
    logic pop;
    logic flush;
    logic clear_flags;
    logic result_rd;
    logic done_seen;
    logic timed_out;
    logic [31:0] status_word;

    assign push_req    = i_we && (i_addr == 2'd1);
    assign push        = push_req && (fifo_count != DEPTH_C);
    assign pop         = (state == IDLE) && (fifo_count != 5'd0);
    assign flush       = i_we && (i_addr == 2'd2) && i_wdata[1];
    assign clear_flags = i_we && (i_addr == 2'd2) && i_wdata[0];
    assign result_rd   = i_re && (i_addr == 2'd3);
    assign wait_next   = wait_cnt + 16'd1;

    // Done is only honoured in WAIT and wins over a timeout landing in the same cycle.
    assign done_seen = (state == WAIT) && i_mmi[8];
    assign timed_out = (state == WAIT) && !i_mmi[8] && (wait_next == TIMEOUT_C);

    assign status_word = {23'd0, fifo_count, overflow_flag, timeout_flag, (state != IDLE), result_valid};
    assign o_irq       = result_valid | timeout_flag | overflow_flag;

    // Command FIFO, staging register and overflow flag.
    // A flush drops whatever remains after this cycle's pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            staging       <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (i_we && (i_addr == 2'd0)) begin
                staging <= i_wdata;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= {i_wdata, staging};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (clear_flags) begin
                overflow_flag <= 1'b0;
            end
            if (push_req && !push) begin
                overflow_flag <= 1'b1;
            end
            if (flush) begin
                rd_ptr     <= wr_ptr;
                fifo_count <= 5'd0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + 5'd1;
                end else if (!push && pop) begin
                    fifo_count <= fifo_count - 5'd1;
                end
            end
        end
    end

    // Issue FSM; also owns the result register and its flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            o_mmi        <= '0;
            o_start      <= 1'b0;
            wait_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            o_start <= 1'b0;
            if (result_rd) begin
                result_valid <= 1'b0;
            end
            if (clear_flags) begin
                timeout_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_mmi   <= fifo_mem[rd_ptr];
                        o_start <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (done_seen) begin
                        result       <= i_mmi;
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end else if (timed_out) begin
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port; reads of the write-only command registers return zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            case (i_addr)
                2'd2:    o_rdata <= status_word;
                2'd3:    o_rdata <= {8'h00, result};
                default: o_rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmi_cp_sequencer.sv
// Bench for mmi_cp_sequencer: directed scenarios plus random traffic, all compared
// every cycle against a transaction-level queue model of the sequencer.
module tb_mmi_cp_sequencer;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    logic [63:0] mmi_cmd;
    logic        start;
    logic [23:0] mmi_status = 24'd0;

    int total_checks = 0;
    int passed_checks = 0;
    bit stim_done = 1'b0;

    // Coprocessor emulation: 0 never done, 1 done at fixed delay, 2 random, 3 manual.
    int          mode = 0;
    int          lat = 0;
    int          since = -1;
    logic [23:0] resp = 24'd0;
    logic [23:0] manual_mmi = 24'd0;

    // Reference model state; m_age is -1 when idle, 1 in the launch cycle, then counts up.
    logic [63:0] mq[$];
    logic [31:0] m_stage = 32'd0;
    int          m_age = -1;
    logic [63:0] m_mmi = 64'd0;
    logic [23:0] m_result = 24'd0;
    bit          m_rv = 1'b0;
    bit          m_to = 1'b0;
    bit          m_ov = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    bit          m_start = 1'b0;

    mmi_cp_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (we),
        .i_re    (re),
        .i_addr  (addr),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_irq   (irq),
        .o_mmi   (mmi_cmd),
        .o_start (start),
        .i_mmi   (mmi_status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (start) since = 0;
        else if (since >= 0) since = since + 1;
        case (mode)
            0: mmi_status = 24'd0;
            1: mmi_status = (since == lat) ? (resp | 24'h000100) : 24'd0;
            2: mmi_status = {8'($urandom), 7'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom)};
            default: mmi_status = manual_mmi;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic modelStep();
        logic [31:0] status;
        bit pop, full, done_now, to_now;
        if (rst) begin
            mq.delete();
            m_stage = 0; m_age = -1; m_mmi = 0; m_result = 0;
            m_rv = 0; m_to = 0; m_ov = 0; m_rdata = 0; m_start = 0;
            return;
        end
        status   = {23'd0, 5'(mq.size()), m_ov, m_to, (m_age > 0), m_rv};
        done_now = (m_age >= 2) && mmi_status[8];
        to_now   = (m_age >= 2) && !mmi_status[8] && (m_age - 1 == TIMEOUT);
        pop      = (m_age < 0) && (mq.size() != 0);
        full     = (mq.size() == FIFO_DEPTH);
        if (re) begin
            if (addr == 2'd2) m_rdata = status;
            else if (addr == 2'd3) m_rdata = {8'h00, m_result};
            else m_rdata = 32'd0;
        end
        if (re && addr == 2'd3) m_rv = 0;
        if (done_now) begin
            m_rv = 1;
            m_result = mmi_status;
        end
        if (we && addr == 2'd2 && wdata[0]) begin
            m_to = 0;
            m_ov = 0;
        end
        if (to_now) m_to = 1;
        if (pop) m_mmi = mq.pop_front();
        if (we && addr == 2'd1) begin
            if (full) m_ov = 1;
            else mq.push_back({wdata, m_stage});
        end
        if (we && addr == 2'd0) m_stage = wdata;
        if (we && addr == 2'd2 && wdata[1]) mq.delete();
        if (pop) m_age = 1;
        else if (m_age == 1) m_age = 2;
        else if (m_age >= 2) m_age = (done_now || to_now) ? -1 : m_age + 1;
        m_start = (m_age == 1);
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] a, input logic [31:0] d);
        we = wr;
        re = rd;
        addr = a;
        wdata = d;
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic waitStart(input int budget);
        int n = 0;
        while (start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_start", 64'(start), 64'd1);
    endtask

    task automatic waitIrq(input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_irq", 64'(irq), 64'd1);
    endtask

    task automatic readCheck(input logic [1:0] a, input logic [31:0] expected, input string name);
        applyStimulus(1'b0, 1'b1, a, 32'd0);
        checkOutput(name, 64'(rdata), 64'(expected));
    endtask

    task automatic runStimulus();
        int starts;
        int r;
        logic [1:0] a;
        logic [31:0] d;

        repeat (2) @(negedge clk);
        checkOutput("reset_mmi", mmi_cmd, 64'd0);
        checkOutput("reset_start", 64'(start), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);
        checkOutput("reset_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        idleCycles(2);

        // Single command, done 5 cycles after the start pulse.
        mode = 1; lat = 5; resp = 24'h00017E;
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0040A155);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h02000100);
        waitStart(10);
        checkOutput("single_mmi", mmi_cmd, 64'h02000100_0040A155);
        waitIrq(20);
        readCheck(2'd2, 32'h1, "single_status_valid");
        readCheck(2'd3, 32'h0000017E, "single_result");
        readCheck(2'd2, 32'h0, "single_status_cleared");

        // Done pulses in IDLE and in the ISSUE cycle must be ignored.
        mode = 3; manual_mmi = 24'h000100;
        idleCycles(3);
        readCheck(2'd2, 32'h0, "stale_idle_status");
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h11112222);
        @(negedge clk);
        checkOutput("stale_issue_start", 64'(start), 64'd1);
        @(negedge clk);
        manual_mmi = 24'h000000;
        readCheck(2'd2, 32'h2, "stale_no_capture");
        manual_mmi = 24'h0001AA;
        idleCycles(1);
        manual_mmi = 24'h000000;
        checkOutput("stale_late_irq", 64'(irq), 64'd1);
        readCheck(2'd3, 32'h000001AA, "stale_late_result");

        // Done in exactly the last allowed WAIT cycle beats the timeout.
        mode = 1; lat = TIMEOUT; resp = 24'h0005C3;
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h33334444);
        waitStart(10);
        waitIrq(TIMEOUT + 20);
        readCheck(2'd2, 32'h1, "race_status");
        readCheck(2'd3, 32'h000005C3, "race_result");

        // One cycle later is too late: timeout, result untouched.
        lat = TIMEOUT + 1;
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h55556666);
        waitStart(10);
        waitIrq(TIMEOUT + 20);
        idleCycles(3);
        readCheck(2'd2, 32'h4, "late_timeout_status");
        readCheck(2'd3, 32'h000005C3, "late_result_kept");
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1);
        readCheck(2'd2, 32'h0, "timeout_cleared");

        // Queue fill behind a stuck command, overflow, then flush.
        mode = 0;
        applyStimulus(1'b1, 1'b0, 2'd0, 32'hCAFE0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 2'd1, 32'h10000000 + 32'(i));
        readCheck(2'd2, 32'h4A, "fill_status");
        waitStart(TIMEOUT + 20);
        checkOutput("fill_second_mmi", mmi_cmd, 64'h10000001_CAFE0000);
        readCheck(2'd2, 32'h3E, "fill_after_timeout");
        mode = 1; lat = 20; resp = 24'h000133;
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h2);
        readCheck(2'd2, 32'h2, "flush_status");
        waitIrq(40);
        readCheck(2'd3, 32'h00000133, "flush_inflight_result");
        readCheck(2'd2, 32'h0, "flush_final_status");

        // Reset in the middle of WAIT with two entries queued.
        mode = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'd1, 32'h20000000 + 32'(i));
        idleCycles(5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mmi", mmi_cmd, 64'd0);
        checkOutput("rst_start", 64'(start), 64'd0);
        checkOutput("rst_irq", 64'(irq), 64'd0);
        checkOutput("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        readCheck(2'd2, 32'h0, "rst_status");
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start) starts++;
        end
        checkOutput("rst_no_restart", 64'(starts), 64'd0);

        // Random register traffic against a random coprocessor.
        mode = 2;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd2) d = {30'd0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
            if (r < 4) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0);
            else if (r < 7) applyStimulus(1'b1, 1'b0, a, d);
            else applyStimulus(1'b0, 1'b1, a, 32'd0);
        end
        idleCycles(5);
    endtask

    initial begin
        fork
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    modelStep();
                    #1;
                    checkOutput("o_start", 64'(start), 64'(m_start));
                    checkOutput("o_mmi", mmi_cmd, m_mmi);
                    checkOutput("o_irq", 64'(irq), 64'(m_rv | m_to | m_ov));
                    checkOutput("o_rdata", 64'(rdata), 64'(m_rdata));
                end
            end
            begin
                runStimulus();
                stim_done = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
